// File: rtl/ps2_key_fifo.sv
// PS/2 keyboard receiver (sync, glitch filter, frame FSM) feeding a show-ahead scan-code FIFO.
// Byte is pushed on the edge that processes the stop bit; a push while full is dropped and flagged.
module ps2_key_fifo #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     keyboard_clock,
  input  logic                     keyboard_data,
  input  logic                     rd_en,
  input  logic                     clear,
  input  logic                     err_clr,
  output logic [7:0]               key_data,
  output logic                     key_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     parity_err,
  output logic                     frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_s, dat_s;
  logic                   clk_filt, clk_filt_q, sample;
  logic [FW-1:0]          filt_cnt;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], keyboard_clock};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], keyboard_data};
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];

  // Filtered clock flips only on the FILTER_LEN-th consecutive differing sample.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      clk_filt   <= 1'b1;
      clk_filt_q <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_filt_q <= clk_filt;
      if (clk_s == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign sample = clk_filt_q & ~clk_filt;

  state_t        state, state_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shift_q, shift_nxt;
  logic          par_ok, par_ok_nxt;
  logic [TW-1:0] to_cnt, to_cnt_nxt;
  logic          push, frame_evt, parity_evt;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift_q <= '0;
      par_ok  <= 1'b0;
      to_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift_q <= shift_nxt;
      par_ok  <= par_ok_nxt;
      to_cnt  <= to_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_q;
    par_ok_nxt  = par_ok;
    to_cnt_nxt  = '0;
    push        = 1'b0;
    frame_evt   = 1'b0;
    parity_evt  = 1'b0;
    if (sample) begin
      case (state)
        IDLE: begin
          if (!dat_s) begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
          end
        end
        DATA: begin
          shift_nxt   = {dat_s, shift_q[7:1]};
          bit_cnt_nxt = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
        PARITY: begin
          par_ok_nxt = ^{shift_q, dat_s};
          state_nxt  = STOP;
        end
        STOP: begin
          if (!dat_s)       frame_evt  = 1'b1;
          else if (!par_ok) parity_evt = 1'b1;
          else              push       = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (state != IDLE) begin
      // A stalled frame is abandoned once the inter-sample gap reaches TIMEOUT_CYC.
      if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
        state_nxt = IDLE;
        frame_evt = 1'b1;
      end else begin
        to_cnt_nxt = to_cnt + 1'b1;
      end
    end
  end

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          full, empty, pop, wr, ovf_evt;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign pop     = rd_en & ~empty;
  assign wr      = push & (~full | pop);
  assign ovf_evt = push & full & ~pop & ~clear;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (wr && !clear) mem[wr_ptr] <= shift_q;
  end

  // An error event in the same cycle as err_clr leaves the flag set.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      overflow   <= (overflow   & ~err_clr) | ovf_evt;
      parity_err <= (parity_err & ~err_clr) | parity_evt;
      frame_err  <= (frame_err  & ~err_clr) | frame_evt;
    end
  end

  assign count     = cnt;
  assign key_valid = ~empty;
  assign key_data  = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Bench for ps2_key_fifo: bit-banged PS/2 frames, a queue of expected scan codes popped on rd_en.
module tb_ps2_key_fifo;
  localparam int DEPTH = 8;
  localparam int TO    = 200;
  localparam int HALF  = 10;

  logic       CLK = 1'b0;
  logic       reset, keyboard_clock, keyboard_data, rd_en, clear, err_clr;
  logic [7:0] key_data;
  logic       key_valid;
  logic [3:0] count;
  logic       overflow, parity_err, frame_err;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       ovf_exp = 1'b0;

  ps2_key_fifo #(.DEPTH(DEPTH), .SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .reset(reset), .keyboard_clock(keyboard_clock), .keyboard_data(keyboard_data),
    .rd_en(rd_en), .clear(clear), .err_clr(err_clr), .key_data(key_data), .key_valid(key_valid),
    .count(count), .overflow(overflow), .parity_err(parity_err), .frame_err(frame_err)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // pop_at_fall raises rd_en for the single cycle whose closing edge processes this sample.
  task automatic ps2_bit(input logic v, input logic pop_at_fall);
    keyboard_data = v;
    tick(HALF);
    keyboard_clock = 1'b0;
    if (pop_at_fall) begin
      tick(6);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      tick(HALF - 7);
    end else begin
      tick(HALF);
    end
    keyboard_clock = 1'b1;
  endtask

  task automatic glitch(input logic v);
    tick(HALF);
    keyboard_data  = v;
    keyboard_clock = 1'b0;
    tick(3);
    keyboard_clock = 1'b1;
    tick(HALF);
  endtask

  task automatic drain_one();
    checks++;
    if (key_valid !== 1'b1 || key_data !== exp_q[0]) begin
      errors++;
      $display("FAIL pop_head: valid=%0b data=%02h, expected valid=1 data=%02h", key_valid, key_data, exp_q[0]);
    end
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    void'(exp_q.pop_front());
  endtask

  task automatic send_frame(input logic [7:0] b, input logic good_par, input logic stop_v, input logic pop_at_stop);
    logic p;
    p = good_par ? ~(^b) : ^b;
    if (pop_at_stop) begin
      checks++;
      if (key_data !== exp_q[0]) begin
        errors++;
        $display("FAIL pop_with_push_head: got %02h, expected %02h", key_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    if (good_par && stop_v) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else ovf_exp = 1'b1;
    end
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
    ps2_bit(p, 1'b0);
    ps2_bit(stop_v, pop_at_stop);
    tick(HALF);
  endtask

  task automatic test_reset();
    tick(3);
    checks++;
    if (key_valid !== 1'b0 || key_data !== 8'h00) begin
      errors++; $display("FAIL reset_head: valid=%0b data=%02h, expected 0/00", key_valid, key_data);
    end
    checks++;
    if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++;
    if ({overflow, parity_err, frame_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %03b expected 000", {overflow, parity_err, frame_err});
    end
    reset = 1'b1;
    tick(3);
  endtask

  task automatic test_single();
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    checks++;
    if (key_valid !== 1'b1 || key_data !== 8'h1C || count !== 4'd1) begin
      errors++; $display("FAIL single_rx: valid=%0b data=%02h count=%0d, expected 1/1c/1", key_valid, key_data, count);
    end
    drain_one();
    checks++;
    if (key_valid !== 1'b0 || count !== 4'd0 || key_data !== 8'h00) begin
      errors++; $display("FAIL single_pop: valid=%0b count=%0d data=%02h, expected 0/0/00", key_valid, count, key_data);
    end
  endtask

  task automatic test_parity();
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (parity_err !== 1'b1 || frame_err !== 1'b0 || count !== 4'd0) begin
      errors++; $display("FAIL parity_bad: perr=%0b ferr=%0b count=%0d, expected 1/0/0", parity_err, frame_err, count);
    end
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    checks++;
    if (parity_err !== 1'b0) begin errors++; $display("FAIL parity_clr: got %0b expected 0", parity_err); end
  endtask

  task automatic test_overflow();
    for (int v = 1; v <= 9; v++) send_frame(8'(v), 1'b1, 1'b1, 1'b0);
    checks++;
    if (count !== 4'(exp_q.size()) || count !== 4'd8) begin
      errors++; $display("FAIL full_count: got %0d expected %0d", count, exp_q.size());
    end
    checks++;
    if (overflow !== ovf_exp || overflow !== 1'b1) begin
      errors++; $display("FAIL overflow_set: got %0b expected 1", overflow);
    end
    checks++;
    if (key_data !== 8'h01) begin errors++; $display("FAIL full_head: got %02h expected 01", key_data); end
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    ovf_exp = 1'b0;
    send_frame(8'h0A, 1'b1, 1'b1, 1'b1);
    checks++;
    if (count !== 4'd8 || overflow !== ovf_exp) begin
      errors++; $display("FAIL pop_push_full: count=%0d ovf=%0b, expected 8/%0b", count, overflow, ovf_exp);
    end
    while (exp_q.size() > 0) drain_one();
    checks++;
    if (count !== 4'd0 || key_valid !== 1'b0) begin
      errors++; $display("FAIL drained: count=%0d valid=%0b, expected 0/0", count, key_valid);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] b;
    b = 8'hA5;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(b[i], 1'b0);
    tick(TO + 20);
    checks++;
    if (frame_err !== 1'b1 || count !== 4'd0) begin
      errors++; $display("FAIL timeout: ferr=%0b count=%0d, expected 1/0", frame_err, count);
    end
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    checks++;
    if (key_data !== 8'h5A || count !== 4'd1 || parity_err !== 1'b0) begin
      errors++; $display("FAIL after_timeout: data=%02h count=%0d perr=%0b, expected 5a/1/0", key_data, count, parity_err);
    end
    drain_one();
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL frame_clr: got %0b expected 0", frame_err); end
  endtask

  task automatic test_glitch();
    logic [7:0] b;
    b = 8'h3C;
    glitch(1'b0);
    exp_q.push_back(b);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(b[i], 1'b0);
    glitch(~b[4]);
    for (int i = 4; i < 8; i++) ps2_bit(b[i], 1'b0);
    ps2_bit(~(^b), 1'b0);
    ps2_bit(1'b1, 1'b0);
    tick(HALF);
    checks++;
    if (count !== 4'd1 || key_data !== 8'h3C || parity_err !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL glitch_rx: count=%0d data=%02h perr=%0b ferr=%0b, expected 1/3c/0/0",
                         count, key_data, parity_err, frame_err);
    end
    drain_one();
  endtask

  task automatic test_clear_empty();
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
    checks++;
    if (count !== 4'd0 || key_valid !== 1'b0) begin
      errors++; $display("FAIL empty_pop: count=%0d valid=%0b, expected 0/0", count, key_valid);
    end
    send_frame(8'h11, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1, 1'b0);
    checks++;
    if (count !== 4'd2) begin errors++; $display("FAIL pre_clear: got %0d expected 2", count); end
    clear = 1'b1; tick(1); clear = 1'b0;
    exp_q.delete();
    checks++;
    if (count !== 4'd0 || key_valid !== 1'b0 || key_data !== 8'h00) begin
      errors++; $display("FAIL clear: count=%0d valid=%0b data=%02h, expected 0/0/00", count, key_valid, key_data);
    end
    send_frame(8'h33, 1'b1, 1'b1, 1'b0);
    drain_one();
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    b = 8'h29;
    send_frame(8'h31, 1'b1, 1'b1, 1'b0);
    send_frame(8'h32, 1'b1, 1'b1, 1'b0);
    send_frame(8'h33, 1'b1, 1'b1, 1'b0);
    send_frame(8'h44, 1'b0, 1'b1, 1'b0);
    checks++;
    if (count !== 4'd3 || parity_err !== 1'b1) begin
      errors++; $display("FAIL pre_reset: count=%0d perr=%0b, expected 3/1", count, parity_err);
    end
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(b[i], 1'b0);
    keyboard_data = b[5];
    tick(HALF / 2);
    reset = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0 || key_valid !== 1'b0 || key_data !== 8'h00 ||
        {overflow, parity_err, frame_err} !== 3'b000) begin
      errors++; $display("FAIL async_reset: count=%0d valid=%0b data=%02h flags=%03b, expected all 0",
                         count, key_valid, key_data, {overflow, parity_err, frame_err});
    end
    exp_q.delete();
    keyboard_data = 1'b1;
    tick(4);
    reset = 1'b1;
    tick(5);
    send_frame(b, 1'b1, 1'b1, 1'b0);
    checks++;
    if (count !== 4'd1 || key_data !== 8'h29 || frame_err !== 1'b0) begin
      errors++; $display("FAIL after_reset: count=%0d data=%02h ferr=%0b, expected 1/29/0", count, key_data, frame_err);
    end
    drain_one();
  endtask

  initial begin
    reset = 1'b0; keyboard_clock = 1'b1; keyboard_data = 1'b1;
    rd_en = 1'b0; clear = 1'b0; err_clr = 1'b0;
    test_reset();
    test_single();
    test_parity();
    test_overflow();
    test_timeout();
    test_glitch();
    test_clear_empty();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_key_fifo.md
PS2_KEY_FIFO -- requirements
Module: ps2_key_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, scan-code FIFO entries; power of two, >= 2.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser flops per PS/2 line.
REQ-003 SHALL have parameter FILTER_LEN, default 4, consecutive equal samples needed to change filtered PS/2 clock.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 20000, CLK cycles allowed between PS/2 bit samples inside a frame.
REQ-005 SHALL have port CLK  input  1  single system clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port keyboard_clock  input  1  raw PS/2 clock, asynchronous.
REQ-008 SHALL have port keyboard_data  input  1  raw PS/2 data, asynchronous.
REQ-009 SHALL have port rd_en  input  1  pop head entry.
REQ-010 SHALL have port clear  input  1  flush FIFO.
REQ-011 SHALL have port err_clr  input  1  clear sticky error flags.
REQ-012 SHALL have port key_data  output  8  head entry (show-ahead), 0 when empty.
REQ-013 SHALL have port key_valid  output  1  FIFO non-empty.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  entries held.
REQ-015 SHALL have ports overflow, parity_err, frame_err  output  1 each  sticky error flags.

Function
REQ-016 SHALL pass both PS/2 lines through SYNC_STAGES flops before use.
REQ-017 SHALL change filtered clock level only after FILTER_LEN consecutive synchronised samples of the new level; shorter pulses ignored.
REQ-018 SHALL generate one sample event per filtered-clock falling edge, data sampled from synchronised data line in that cycle.
REQ-019 SHALL implement FSM IDLE, DATA, PARITY, STOP, advancing only on sample events (except timeout).
REQ-020 IDLE: sample with data 0 -> DATA, bit counter 0; data 1 -> stay IDLE.
REQ-021 DATA: shift bit in LSB-first; after 8th bit -> PARITY.
REQ-022 PARITY: record parity check (8 data bits + parity bit SHALL contain odd number of ones) -> STOP.
REQ-023 STOP: data 1 and parity good -> push byte; data 0 -> set frame_err, no push; parity bad -> set parity_err, no push; always -> IDLE.
REQ-024 Push SHALL occur on the CLK edge processing the STOP sample; key_valid/count reflect it the following cycle.
REQ-025 Outside IDLE, SHALL count CLK cycles since last sample event; on reaching TIMEOUT_CYC -> IDLE, set frame_err, discard partial byte.
REQ-026 Push while full (and no simultaneous pop) SHALL drop new byte, set overflow, leave contents unchanged.
REQ-027 rd_en while empty SHALL be ignored; pointers and count unchanged.
REQ-028 Simultaneous push and pop SHALL both complete, count unchanged, including when full (no overflow) and when empty-then-push is not applicable (pop ignored if empty, push proceeds).
REQ-029 clear SHALL empty FIFO in one cycle, priority over push and pop (same-cycle push discarded); FSM and flags unaffected.
REQ-030 err_clr SHALL zero all three flags; an error event in the same cycle SHALL win (flag set).
REQ-031 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.

Reset
REQ-032 On reset low SHALL immediately force: FSM IDLE, pointers/count 0, key_valid 0, key_data 0, all flags 0, timeout counter 0, synchroniser and filtered-clock flops 1 (bus idle).
REQ-033 Reset asserted mid-frame SHALL discard the partial frame; first frame after release SHALL be received normally.

Verification
REQ-034 Frame 0x1C (start 0, data LSB-first, parity 0, stop 1) -> key_valid=1, key_data=0x1C, count=1; rd_en one cycle -> count=0, key_valid=0.
REQ-035 Frame 0xF0 with parity bit 0 -> parity_err=1, count=0; err_clr -> parity_err=0.
REQ-036 DEPTH=8, nine valid frames 0x01..0x09, no rd_en -> count=8, overflow=1, key_data=0x01; then pop with simultaneous 10th push -> count=8, overflow stays 1 only from earlier event.
REQ-037 Frame stopped after 4 data bits, idle TIMEOUT_CYC+1 cycles -> frame_err=1, FSM IDLE; next frame 0x5A -> key_data=0x5A.
REQ-038 keyboard_clock low glitch of FILTER_LEN-1 cycles in IDLE and mid-frame -> no sample; subsequent frame 0x3C received intact.
REQ-039 reset pulled low during bit 5 with count=3 -> all outputs 0 same cycle; after release frame 0x29 -> count=1, key_data=0x29.
